shadow_capture_ring: RTL and testbench
======================================

# shadow_capture_ring

Multi-snapshot successor to the single-shot shadow capture block: samples a `DFF_BITS`-wide vector of local state into a `DEPTH`-entry snapshot ring, optionally gated by a masked trigger match. It then serialises the oldest snapshot onto `CHAINS_OUT` lockstep scan chains under a valid/ready handshake. It sits at a leaf of the debug-dump tree and feeds a parent chain arbiter.

## Interface
- `DFF_BITS`, 8: captured vector width (≥1)
- `CHAINS_OUT`, 1: serial output chains (1..DFF_BITS)
- `DEPTH`, 4: snapshot slots (power of two, ≥2)
- `OVERWRITE`, 0: 1 = capture into full ring evicts oldest; 0 = new capture dropped
- `clk` in 1: the single clock; all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `din` in DFF_BITS: local DFF state to capture
- `capture_en` in 1: capture request
- `trig_mode` in 1: 0 = capture on `capture_en`; 1 = capture on `capture_en` AND `(din & trig_mask) == (trig_val & trig_mask)`
- `trig_mask`, `trig_val` in DFF_BITS: trigger compare operands
- `dump_en` in 1: permit dumping; low pauses output
- `chains_out` out CHAINS_OUT: serial data, one bit per chain
- `chains_out_vld` out CHAINS_OUT: per-chain valid
- `chains_out_rdy` in 1: parent accepts the current beat (shared by all chains)
- `chains_out_last` out 1: final beat of current snapshot
- `snap_count` out clog2(DEPTH)+1: snapshots held in ring (excludes in-flight)
- `full`, `empty` out 1: ring status
- `overflow` out 1: sticky, capture dropped or evicted
- `clr_overflow` in 1: synchronous clear of `overflow`

## Operation
- Chain partition: `LEN = DFF_BITS / CHAINS_OUT`, `EXTRA = DFF_BITS % CHAINS_OUT`. Chain j<CHAINS_OUT-1 carries `din[j*LEN +: LEN]`. The last chain carries `LEN+EXTRA` bits. LSB is sent first.
- Capture accepted: `capture_en` plus trigger condition. Slot `wr_ptr` is written with `din`, and `wr_ptr` increments mod DEPTH.
- Full ring with `OVERWRITE=1`: the oldest slot is evicted (`rd_ptr` also advances, count unchanged) and `overflow` is set.
- Full ring with `OVERWRITE=0`: the capture is discarded and `overflow` is set.
- Simultaneous capture and pop (LOAD) on a full ring: no eviction, no overflow, both pointers advance.
- `clr_overflow` together with a new overflow event: set wins.
- FSM states:
  - IDLE → LOAD when `dump_en` and `!empty`.
  - LOAD (1 cycle): the shift register takes `mem[rd_ptr]`, the ring pops (`rd_ptr`++, count−1), and the beat index clears. LOAD → SHIFT.
  - SHIFT: `chains_out_vld[j] = dump_en && idx < len(j)`. The beat advances when `dump_en && chains_out_rdy`. `chains_out_last` is high while `idx == LEN+EXTRA-1`. On the last accepted beat, go to LOAD if `dump_en && !empty`, else to IDLE.
- `dump_en` low in SHIFT: all vld low, state and data held, no progress.
- Shorter chains drop vld after LEN beats while the last chain finishes its EXTRA beats.
- `chains_out` is 0 whenever the corresponding vld is low.

## Timing
- Reset values:
  - `chains_out`=0, `chains_out_vld`=0, `chains_out_last`=0
  - `snap_count`=0, `empty`=1, `full`=0, `overflow`=0
  - FSM=IDLE, pointers=0
- Capture at edge N: `snap_count` is updated at N+1.
- Dump latency: `dump_en` sampled high at edge N with `!empty` → LOAD at N+1 → first vld at N+2.
- Throughput with `rdy` held 1: one snapshot every `LEN+EXTRA+1` cycles (the +1 is the LOAD bubble).
- A beat transfers on an edge where vld[j] and rdy are both high. Data and vld must stay stable until that transfer.
- Reset asserted mid-dump: immediate return to reset values, and the ring contents are discarded.

## Structure
- Package `shadow_capture_pkg`:
  - `clog2` function
  - FSM state type {IDLE, LOAD, SHIFT}
  - chain-length helper functions `chain_len(j)`
- Sub-module `snapshot_ring`: storage, pointers, count, full/empty, and overwrite/drop/overflow logic.
- Top level: trigger compare, LOAD/SHIFT FSM, per-chain shift registers, output muxing.

## Test plan
- DFF_BITS=8, CHAINS_OUT=1: capture 0xA5, then dump with rdy=1 → vld high for 8 cycles from N+2, bits 1,0,1,0,0,1,0,1, last on the 8th beat, empty=1 afterwards.
- DFF_BITS=10, CHAINS_OUT=3: capture 0x3FF → chains 0 and 1 are valid 3 beats, chain 2 is valid 4 beats, and last is asserted on beat 4.
- DEPTH=4, OVERWRITE=0: capture 0x01..0x05 → count=4, full=1, overflow=1, dump yields 01,02,03,04. With OVERWRITE=1 the dump yields 02,03,04,05.
- trig_mode=1, mask=0xF0, val=0x30: capture_en with din=0x3C → captured; din=0x4C → ignored, count unchanged.
- rdy toggling 1,0,0,1 and dump_en low for 2 cycles mid-snapshot → no beat lost or duplicated, and data stays stable while stalled.
- `rst` asserted during SHIFT → all outputs return to reset values on the same cycle, and the next dump sees `empty`.

Source files
------------

// File: rtl/shadow_capture_ring_pkg.sv
// +----------------------------------------------------------------------------+
// | shadow_capture_pkg : shared types and helpers for shadow_capture_ring      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package shadow_capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // The last chain absorbs the remainder bits when the split is uneven.
   function automatic int chain_len(input int j, input int bits, input int chains);
      int len;
      len = bits / chains;
      return (j == chains - 1) ? (len + bits % chains) : len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shadow_capture_ring_if.sv
// +----------------------------------------------------------------------------+
// | shadow_capture_ring_if : capture/trigger inputs and scan-chain handshake   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shadow_capture_ring_if import shadow_capture_pkg::*; #(
   parameter int DFF_BITS   = 8,
   parameter int CHAINS_OUT = 1,
   parameter int DEPTH      = 4
) ();
   logic [DFF_BITS-1:0]     din;
   logic                    capture_en;
   logic                    trig_mode;
   logic [DFF_BITS-1:0]     trig_mask;
   logic [DFF_BITS-1:0]     trig_val;
   logic                    dump_en;
   logic [CHAINS_OUT-1:0]   chains_out;
   logic [CHAINS_OUT-1:0]   chains_out_vld;
   logic                    chains_out_rdy;
   logic                    chains_out_last;
   logic [clog2(DEPTH):0]   snap_count;
   logic                    full;
   logic                    empty;
   logic                    overflow;
   logic                    clr_overflow;

   modport master (
      output din, capture_en, trig_mode, trig_mask, trig_val, dump_en,
             chains_out_rdy, clr_overflow,
      input  chains_out, chains_out_vld, chains_out_last, snap_count,
             full, empty, overflow
   );

   modport slave (
      input  din, capture_en, trig_mode, trig_mask, trig_val, dump_en,
             chains_out_rdy, clr_overflow,
      output chains_out, chains_out_vld, chains_out_last, snap_count,
             full, empty, overflow
   );
endinterface

`default_nettype wire

// File: rtl/shadow_capture_ring_snapshot_ring.sv
// +----------------------------------------------------------------------------+
// | snapshot_ring : DEPTH-slot snapshot storage with drop/evict overflow logic |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module snapshot_ring import shadow_capture_pkg::*; #(
   parameter int DFF_BITS  = 8,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_push,
   input  wire logic                 i_pop,
   input  wire logic                 i_clr_overflow,
   input  wire logic [DFF_BITS-1:0]  i_din,
   output logic [DFF_BITS-1:0]       o_rd_data,
   output logic [clog2(DEPTH):0]     o_count,
   output logic                      o_full,
   output logic                      o_empty,
   output logic                      o_overflow
);
   localparam int PW       = clog2(DEPTH);
   localparam int CW       = PW + 1;
   localparam bit EVICT_OK = (OVERWRITE != 0);

   logic [DFF_BITS-1:0] r_mem [DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                r_overflow;

   logic w_full, w_empty, w_blocked, w_write, w_evict, w_inc;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   // A pop in the same cycle frees a slot, so only an unpaired push hits a full ring.
   assign w_blocked = i_push && w_full && !i_pop;
   assign w_write   = i_push && (!w_blocked || EVICT_OK);
   assign w_evict   = w_blocked && EVICT_OK;
   assign w_inc     = w_write && !w_evict;

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (i_pop || w_evict) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_inc && !i_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_inc && i_pop) begin
            r_count <= r_count - CW'(1);
         end
         if (w_blocked) begin
            r_overflow <= 1'b1;
         end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/shadow_capture_ring.sv
// +----------------------------------------------------------------------------+
// | shadow_capture_ring : triggered multi-snapshot capture, serial scan dump   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module shadow_capture_ring import shadow_capture_pkg::*; #(
   parameter int DFF_BITS   = 8,
   parameter int CHAINS_OUT = 1,
   parameter int DEPTH      = 4,
   parameter int OVERWRITE  = 0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   shadow_capture_ring_if.slave  io_bus
);
   localparam int LEN    = DFF_BITS / CHAINS_OUT;
   localparam int EXTRA  = DFF_BITS % CHAINS_OUT;
   localparam int MAXLEN = LEN + EXTRA;
   localparam int IW     = clog2(MAXLEN + 1);

   state_t                r_state;
   state_t                w_next;
   logic [IW-1:0]         r_idx;
   logic                  w_hit, w_pop, w_adv, w_at_last;
   logic                  w_empty;
   logic [DFF_BITS-1:0]   w_rd_data;
   logic [CHAINS_OUT-1:0] w_vld, w_bit;

   assign w_hit = io_bus.capture_en &&
                  (!io_bus.trig_mode ||
                   (((io_bus.din ^ io_bus.trig_val) & io_bus.trig_mask) == '0));

   snapshot_ring #(
      .DFF_BITS  (DFF_BITS),
      .DEPTH     (DEPTH),
      .OVERWRITE (OVERWRITE)
   ) u_ring (
      .clk            (clk),
      .rst            (rst),
      .i_push         (w_hit),
      .i_pop          (w_pop),
      .i_clr_overflow (io_bus.clr_overflow),
      .i_din          (io_bus.din),
      .o_rd_data      (w_rd_data),
      .o_count        (io_bus.snap_count),
      .o_full         (io_bus.full),
      .o_empty        (w_empty),
      .o_overflow     (io_bus.overflow)
   );

   assign w_at_last = (r_idx == IW'(MAXLEN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_idx <= '0;
         end else if (w_adv) begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_adv  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (io_bus.dump_en && !w_empty) w_next = LOAD;
         end
         LOAD: begin
            w_pop  = 1'b1;
            w_next = SHIFT;
         end
         SHIFT: begin
            if (io_bus.dump_en && io_bus.chains_out_rdy) begin
               w_adv = 1'b1;
               if (w_at_last) w_next = w_empty ? IDLE : LOAD;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Beats advance in lockstep; shorter chains just fall silent after their length.
   for (genvar j = 0; j < CHAINS_OUT; j++) begin : g_chain
      localparam int CL = chain_len(j, DFF_BITS, CHAINS_OUT);
      logic [CL-1:0] r_sr;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_sr <= '0;
         end else if (w_pop) begin
            r_sr <= w_rd_data[j*LEN +: CL];
         end else if (w_adv) begin
            r_sr <= r_sr >> 1;
         end
      end

      assign w_vld[j] = (r_state == SHIFT) && io_bus.dump_en && (r_idx < IW'(CL));
      assign w_bit[j] = w_vld[j] & r_sr[0];
   end

   assign io_bus.chains_out      = w_bit;
   assign io_bus.chains_out_vld  = w_vld;
   assign io_bus.chains_out_last = (r_state == SHIFT) && w_at_last;
   assign io_bus.empty           = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_shadow_capture_ring.sv
// +----------------------------------------------------------------------------+
// | tb_shadow_capture_ring : directed bench, 8b/1-chain drop and 10b/3-chain   |
// | evict instances. Revision: 1.0                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shadow_capture_ring;
   import shadow_capture_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   shadow_capture_ring_if #(.DFF_BITS(8),  .CHAINS_OUT(1), .DEPTH(4)) bus_a ();
   shadow_capture_ring_if #(.DFF_BITS(10), .CHAINS_OUT(3), .DEPTH(4)) bus_b ();

   shadow_capture_ring #(.DFF_BITS(8), .CHAINS_OUT(1), .DEPTH(4), .OVERWRITE(0)) u_a (
      .clk(clk), .rst(rst), .io_bus(bus_a.slave));
   shadow_capture_ring #(.DFF_BITS(10), .CHAINS_OUT(3), .DEPTH(4), .OVERWRITE(1)) u_b (
      .clk(clk), .rst(rst), .io_bus(bus_b.slave));

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic init_inputs();
      bus_a.din = '0; bus_a.capture_en = 0; bus_a.trig_mode = 0; bus_a.trig_mask = '0;
      bus_a.trig_val = '0; bus_a.dump_en = 0; bus_a.chains_out_rdy = 0; bus_a.clr_overflow = 0;
      bus_b.din = '0; bus_b.capture_en = 0; bus_b.trig_mode = 0; bus_b.trig_mask = '0;
      bus_b.trig_val = '0; bus_b.dump_en = 0; bus_b.chains_out_rdy = 0; bus_b.clr_overflow = 0;
   endtask

   task automatic capture_a(input logic [7:0] v);
      next_cycle(); bus_a.din = v; bus_a.capture_en = 1;
      next_cycle(); bus_a.capture_en = 0;
   endtask

   task automatic capture_b(input logic [9:0] v);
      next_cycle(); bus_b.din = v; bus_b.capture_en = 1;
      next_cycle(); bus_b.capture_en = 0;
   endtask

   task automatic test_reset();
      init_inputs();
      repeat (2) next_cycle();
      #1;
      n_cmp++; if (bus_a.chains_out_vld !== 1'b0) begin n_err++; $display("FAIL rst_a_vld: got %b exp 0", bus_a.chains_out_vld); end
      n_cmp++; if (bus_a.chains_out !== 1'b0) begin n_err++; $display("FAIL rst_a_data: got %b exp 0", bus_a.chains_out); end
      n_cmp++; if (bus_a.chains_out_last !== 1'b0) begin n_err++; $display("FAIL rst_a_last: got %b exp 0", bus_a.chains_out_last); end
      n_cmp++; if (bus_a.snap_count !== 3'd0) begin n_err++; $display("FAIL rst_a_count: got %0d exp 0", bus_a.snap_count); end
      n_cmp++; if ({bus_a.empty, bus_a.full, bus_a.overflow} !== 3'b100) begin n_err++; $display("FAIL rst_a_flags: got %b exp 100", {bus_a.empty, bus_a.full, bus_a.overflow}); end
      n_cmp++; if (bus_b.chains_out_vld !== 3'b000) begin n_err++; $display("FAIL rst_b_vld: got %b exp 000", bus_b.chains_out_vld); end
      n_cmp++; if ({bus_b.empty, bus_b.full, bus_b.overflow} !== 3'b100) begin n_err++; $display("FAIL rst_b_flags: got %b exp 100", {bus_b.empty, bus_b.full, bus_b.overflow}); end
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_basic_a();
      logic [7:0] v;
      v = 8'hA5;
      capture_a(v);
      #1;
      n_cmp++; if (bus_a.snap_count !== 3'd1) begin n_err++; $display("FAIL basic_count: got %0d exp 1", bus_a.snap_count); end
      bus_a.dump_en = 1; bus_a.chains_out_rdy = 1;
      #1;
      n_cmp++; if (bus_a.chains_out_vld !== 1'b0) begin n_err++; $display("FAIL basic_idle_vld: got %b exp 0", bus_a.chains_out_vld); end
      next_cycle(); #1;
      n_cmp++; if (bus_a.chains_out_vld !== 1'b0) begin n_err++; $display("FAIL basic_load_vld: got %b exp 0", bus_a.chains_out_vld); end
      for (int k = 0; k < 8; k++) begin
         next_cycle(); #1;
         n_cmp++; if (bus_a.chains_out_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld beat %0d: got %b exp 1", k, bus_a.chains_out_vld); end
         n_cmp++; if (bus_a.chains_out !== v[k]) begin n_err++; $display("FAIL basic_data beat %0d: got %b exp %b", k, bus_a.chains_out, v[k]); end
         n_cmp++; if (bus_a.chains_out_last !== (k == 7)) begin n_err++; $display("FAIL basic_last beat %0d: got %b exp %b", k, bus_a.chains_out_last, (k == 7)); end
      end
      next_cycle(); #1;
      n_cmp++; if (bus_a.chains_out_vld !== 1'b0) begin n_err++; $display("FAIL basic_done_vld: got %b exp 0", bus_a.chains_out_vld); end
      n_cmp++; if (bus_a.empty !== 1'b1) begin n_err++; $display("FAIL basic_done_empty: got %b exp 1", bus_a.empty); end
      bus_a.dump_en = 0;
   endtask

   task automatic test_multi_chain_b();
      logic [9:0] vals [2];
      logic [9:0] v;
      logic [2:0] ev, ed;
      vals[0] = 10'h3FF; vals[1] = 10'h2C9;
      capture_b(vals[0]);
      capture_b(vals[1]);
      #1;
      n_cmp++; if (bus_b.snap_count !== 3'd2) begin n_err++; $display("FAIL mc_count: got %0d exp 2", bus_b.snap_count); end
      bus_b.dump_en = 1; bus_b.chains_out_rdy = 1;
      for (int s = 0; s < 2; s++) begin
         v = vals[s];
         next_cycle(); #1;
         n_cmp++; if (bus_b.chains_out_vld !== 3'b000) begin n_err++; $display("FAIL mc_load_vld snap %0d: got %b exp 000", s, bus_b.chains_out_vld); end
         for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            ev = '0; ed = '0;
            for (int j = 0; j < 3; j++) begin
               if (k < ((j == 2) ? 4 : 3)) begin ev[j] = 1'b1; ed[j] = v[j*3 + k]; end
            end
            n_cmp++; if (bus_b.chains_out_vld !== ev) begin n_err++; $display("FAIL mc_vld snap %0d beat %0d: got %b exp %b", s, k, bus_b.chains_out_vld, ev); end
            n_cmp++; if (bus_b.chains_out !== ed) begin n_err++; $display("FAIL mc_data snap %0d beat %0d: got %b exp %b", s, k, bus_b.chains_out, ed); end
            n_cmp++; if (bus_b.chains_out_last !== (k == 3)) begin n_err++; $display("FAIL mc_last snap %0d beat %0d: got %b exp %b", s, k, bus_b.chains_out_last, (k == 3)); end
         end
      end
      next_cycle(); #1;
      n_cmp++; if ({bus_b.empty, bus_b.chains_out_vld} !== 4'b1000) begin n_err++; $display("FAIL mc_done: got %b exp 1000", {bus_b.empty, bus_b.chains_out_vld}); end
      bus_b.dump_en = 0;
   endtask

   task automatic test_overflow_drop_a();
      logic [7:0] acc;
      int got [4];
      int last_at [4];
      int n, beat;
      next_cycle();
      for (int v = 1; v <= 5; v++) begin
         bus_a.din = 8'(v); bus_a.capture_en = 1;
         next_cycle();
      end
      bus_a.capture_en = 0;
      #1;
      n_cmp++; if (bus_a.snap_count !== 3'd4) begin n_err++; $display("FAIL drop_count: got %0d exp 4", bus_a.snap_count); end
      n_cmp++; if ({bus_a.full, bus_a.empty, bus_a.overflow} !== 3'b101) begin n_err++; $display("FAIL drop_flags: got %b exp 101", {bus_a.full, bus_a.empty, bus_a.overflow}); end
      bus_a.din = 8'h06; bus_a.capture_en = 1; bus_a.clr_overflow = 1;
      next_cycle();
      bus_a.capture_en = 0;
      #1;
      n_cmp++; if (bus_a.overflow !== 1'b1) begin n_err++; $display("FAIL drop_set_wins: got %b exp 1", bus_a.overflow); end
      next_cycle();
      bus_a.clr_overflow = 0;
      #1;
      n_cmp++; if (bus_a.overflow !== 1'b0) begin n_err++; $display("FAIL drop_clear: got %b exp 0", bus_a.overflow); end
      bus_a.dump_en = 1; bus_a.chains_out_rdy = 1;
      n = 0; beat = 0; acc = '0;
      for (int c = 0; c < 80; c++) begin
         if (n == 4) break;
         next_cycle(); #1;
         if (bus_a.chains_out_vld[0]) begin
            acc[beat] = bus_a.chains_out[0];
            if (bus_a.chains_out_last) begin got[n] = int'(acc); last_at[n] = c; n++; beat = 0; end
            else beat++;
         end
      end
      n_cmp++; if (n != 4) begin n_err++; $display("FAIL drop_dump_timeout: got %0d snapshots exp 4", n); end
      for (int i = 0; i < n; i++) begin
         n_cmp++; if (got[i] != i + 1) begin n_err++; $display("FAIL drop_dump_val %0d: got %0h exp %0h", i, got[i], i + 1); end
      end
      for (int i = 1; i < n; i++) begin
         n_cmp++; if (last_at[i] - last_at[i-1] != 9) begin n_err++; $display("FAIL drop_throughput %0d: got %0d cycles exp 9", i, last_at[i] - last_at[i-1]); end
      end
      next_cycle();
      bus_a.dump_en = 0;
      #1;
      n_cmp++; if (bus_a.empty !== 1'b1) begin n_err++; $display("FAIL drop_empty: got %b exp 1", bus_a.empty); end
   endtask

   task automatic test_overwrite_b();
      logic [9:0] acc;
      int got [4];
      int n, k;
      next_cycle();
      for (int v = 1; v <= 5; v++) begin
         bus_b.din = 10'(v); bus_b.capture_en = 1;
         next_cycle();
      end
      bus_b.capture_en = 0;
      #1;
      n_cmp++; if (bus_b.snap_count !== 3'd4) begin n_err++; $display("FAIL evict_count: got %0d exp 4", bus_b.snap_count); end
      n_cmp++; if ({bus_b.full, bus_b.overflow} !== 2'b11) begin n_err++; $display("FAIL evict_flags: got %b exp 11", {bus_b.full, bus_b.overflow}); end
      bus_b.dump_en = 1; bus_b.chains_out_rdy = 1;
      n = 0; k = 0; acc = '0;
      for (int c = 0; c < 80; c++) begin
         if (n == 4) break;
         next_cycle(); #1;
         if (bus_b.chains_out_vld != 3'b000) begin
            for (int j = 0; j < 3; j++) begin
               if (bus_b.chains_out_vld[j]) acc[j*3 + k] = bus_b.chains_out[j];
            end
            if (bus_b.chains_out_last) begin got[n] = int'(acc); n++; k = 0; acc = '0; end
            else k++;
         end
      end
      n_cmp++; if (n != 4) begin n_err++; $display("FAIL evict_dump_timeout: got %0d snapshots exp 4", n); end
      for (int i = 0; i < n; i++) begin
         n_cmp++; if (got[i] != i + 2) begin n_err++; $display("FAIL evict_dump_val %0d: got %0h exp %0h", i, got[i], i + 2); end
      end
      next_cycle();
      bus_b.dump_en = 0;
   endtask

   task automatic test_trigger_a();
      bus_a.trig_mode = 1; bus_a.trig_mask = 8'hF0; bus_a.trig_val = 8'h30;
      capture_a(8'h3C);
      #1;
      n_cmp++; if (bus_a.snap_count !== 3'd1) begin n_err++; $display("FAIL trig_match: got %0d exp 1", bus_a.snap_count); end
      capture_a(8'h4C);
      #1;
      n_cmp++; if (bus_a.snap_count !== 3'd1) begin n_err++; $display("FAIL trig_nomatch: got %0d exp 1", bus_a.snap_count); end
      bus_a.trig_mode = 0;
   endtask

   task automatic test_stall_a();
      logic [7:0] v;
      bit de [14];
      bit rd [14];
      bit found, exp_vld;
      int beat;
      v = 8'h3C;
      de = '{1,1,1,1,1,0,0,1,1,1,1,1,1,1};
      rd = '{1,1,0,0,1,1,1,1,1,1,1,1,1,1};
      bus_a.dump_en = 1; bus_a.chains_out_rdy = 0;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         next_cycle(); #1;
         if (bus_a.chains_out_vld[0]) begin found = 1; break; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL stall_start_timeout: got no vld exp vld"); end
      beat = 0;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) next_cycle();
         bus_a.dump_en = de[c]; bus_a.chains_out_rdy = rd[c];
         #1;
         exp_vld = de[c] && (beat < 8);
         n_cmp++; if (bus_a.chains_out_vld !== exp_vld) begin n_err++; $display("FAIL stall_vld cyc %0d: got %b exp %b", c, bus_a.chains_out_vld, exp_vld); end
         n_cmp++; if (bus_a.chains_out !== (exp_vld ? v[beat[2:0]] : 1'b0)) begin n_err++; $display("FAIL stall_data cyc %0d: got %b exp %b", c, bus_a.chains_out, exp_vld ? v[beat[2:0]] : 1'b0); end
         n_cmp++; if (bus_a.chains_out_last !== (beat == 7)) begin n_err++; $display("FAIL stall_last cyc %0d: got %b exp %b", c, bus_a.chains_out_last, (beat == 7)); end
         if (exp_vld && rd[c]) beat++;
      end
      n_cmp++; if (beat != 8 || bus_a.empty !== 1'b1) begin n_err++; $display("FAIL stall_beats: got %0d beats empty=%b exp 8 empty=1", beat, bus_a.empty); end
      bus_a.dump_en = 0;
   endtask

   task automatic test_reset_mid_b();
      capture_b(10'h155);
      capture_b(10'h0AA);
      bus_b.dump_en = 1; bus_b.chains_out_rdy = 1;
      next_cycle();
      next_cycle(); #1;
      n_cmp++; if ({bus_b.chains_out_vld, bus_b.chains_out} !== 6'b111_101) begin n_err++; $display("FAIL rmid_beat0: got %b exp 111101", {bus_b.chains_out_vld, bus_b.chains_out}); end
      next_cycle(); #1;
      n_cmp++; if (bus_b.snap_count !== 3'd1) begin n_err++; $display("FAIL rmid_count_pre: got %0d exp 1", bus_b.snap_count); end
      rst = 1'b0;
      #1;
      n_cmp++; if ({bus_b.chains_out_vld, bus_b.chains_out, bus_b.chains_out_last} !== 7'b0) begin n_err++; $display("FAIL rmid_outputs: got %b exp 0000000", {bus_b.chains_out_vld, bus_b.chains_out, bus_b.chains_out_last}); end
      n_cmp++; if (bus_b.snap_count !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d exp 0", bus_b.snap_count); end
      n_cmp++; if ({bus_b.empty, bus_b.full, bus_b.overflow} !== 3'b100) begin n_err++; $display("FAIL rmid_flags: got %b exp 100", {bus_b.empty, bus_b.full, bus_b.overflow}); end
      next_cycle();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         next_cycle(); #1;
         n_cmp++; if (bus_b.chains_out_vld !== 3'b000) begin n_err++; $display("FAIL rmid_post_vld cyc %0d: got %b exp 000", c, bus_b.chains_out_vld); end
      end
      bus_b.dump_en = 0;
   endtask

   initial begin
      test_reset();
      test_basic_a();
      test_multi_chain_b();
      test_overflow_drop_a();
      test_overwrite_b();
      test_trigger_a();
      test_stall_a();
      test_reset_mid_b();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
